// File: rtl/fir_serial_mac_if.sv
// Sample, coefficient-write and result signals of the serial-MAC FIR filter.
// The master drives samples and coefficients; the slave is the filter.
interface fir_serial_mac_if #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int AW = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 coef_wr;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 fir_valid;
  logic signed [DW-1:0] fir_d;

  modport master (
    output in_valid, in_data, coef_wr, coef_addr, coef_data,
    input  in_ready, fir_valid, fir_d
  );

  modport slave (
    input  in_valid, in_data, coef_wr, coef_addr, coef_data,
    output in_ready, fir_valid, fir_d
  );
endinterface

// File: rtl/fir_serial_mac.sv
// Streaming TAPS-tap direct-form FIR with one time-multiplexed multiplier.
// One accepted sample yields one rounded, saturated output after TAPS MAC cycles.
module fir_serial_mac #(
  parameter int TAPS = 32,
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 15,
  parameter int ACCW = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  fir_serial_mac_if.slave         bus
);
  localparam int AW = $clog2(TAPS);
  localparam logic signed [ACCW-1:0] RND_C   = {{(ACCW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [AW-1:0]          cnt_r;
  logic signed [ACCW-1:0] acc_r;
  logic signed [DW-1:0]   x_r [TAPS];
  logic signed [CW-1:0]   c_r [TAPS];
  logic                   fir_valid_r;
  logic signed [DW-1:0]   fir_d_r;

  logic                     in_ready_s;
  logic                     accept_s;
  logic                     mac_en_s;
  logic                     done_s;
  logic                     coef_we_s;
  logic signed [DW+CW-1:0]  prod_s;
  logic signed [ACCW-1:0]   rnd_s;
  logic signed [ACCW-1:0]   shf_s;

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACCW-1:0] v);
    logic signed [DW-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DW-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DW-1:0];
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = MAC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MAC: begin
        if (cnt_r == AW'(TAPS - 1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MAC;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Per-state control strobes; coefficient writes are locked out outside IDLE
  always_comb begin
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    mac_en_s   = 1'b0;
    done_s     = 1'b0;
    coef_we_s  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        accept_s   = bus.in_valid;
        coef_we_s  = bus.coef_wr;
      end
      MAC:     mac_en_s = 1'b1;
      DONE:    done_s   = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign prod_s = (DW+CW)'(x_r[cnt_r]) * (DW+CW)'(c_r[cnt_r]);
  assign rnd_s  = acc_r + RND_C;
  assign shf_s  = rnd_s >>> FRAC;

  // Delay line, coefficient bank, accumulator and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= '0;
      acc_r       <= '0;
      fir_valid_r <= 1'b0;
      fir_d_r     <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_r[k] <= '0;
        c_r[k] <= '0;
      end
    end else begin
      if (coef_we_s) begin
        c_r[bus.coef_addr] <= bus.coef_data;
      end
      if (accept_s) begin
        for (int k = TAPS - 1; k > 0; k--) begin
          x_r[k] <= x_r[k-1];
        end
        x_r[0] <= bus.in_data;
        acc_r  <= '0;
        cnt_r  <= '0;
      end else if (mac_en_s) begin
        acc_r <= acc_r + ACCW'(prod_s);
        cnt_r <= cnt_r + AW'(1);
      end
      fir_valid_r <= done_s;
      if (done_s) begin
        fir_d_r <= sat_dw(shf_s);
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.fir_valid = fir_valid_r;
  assign bus.fir_d     = fir_d_r;
endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac: reset, impulse, saturation, rounding,
// handshake pacing, coefficient lockout and mid-computation reset.
module tb_fir_serial_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  fir_serial_mac_if #(.DW(16), .CW(16), .AW(5)) bus ();

  fir_serial_mac #(.TAPS(32), .DW(16), .CW(16), .FRAC(15), .ACCW(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] exp_d;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_coef(input logic [4:0] a, input logic [15:0] d);
    bus.coef_wr   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = d;
    @(negedge clk);
    bus.coef_wr   = 1'b0;
  endtask

  // wr_at: -1 = coefficient write together with the accept, >=0 = at that MAC count, else none
  task automatic send(input logic [15:0] x, input int wr_at, input logic [4:0] wa,
                      input logic [15:0] wd, output logic [15:0] y);
    int n;
    int lat;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 200), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    if (wr_at == -1) begin
      bus.coef_wr = 1'b1; bus.coef_addr = wa; bus.coef_data = wd;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.coef_wr  = 1'b0;
    lat = 0;
    while (!bus.fir_valid && lat < 100) begin
      if (lat == wr_at) begin
        bus.coef_wr = 1'b1; bus.coef_addr = wa; bus.coef_data = wd;
      end else begin
        bus.coef_wr = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.coef_wr = 1'b0;
    chk("latency", 32'(lat), 32'd33);
    y = bus.fir_d;
  endtask

  initial begin
    logic [15:0] y;
    int idx, nout, last, cyc, run, nacc, lacc, pulses;

    tbl[0] = '{"rnd_4000", 16'h4000, 16'h0001};
    tbl[1] = '{"rnd_3fff", 16'h3FFF, 16'h0000};
    tbl[2] = '{"rnd_c000", 16'hC000, 16'h0000};
    tbl[3] = '{"rnd_bfff", 16'hBFFF, 16'hFFFF};
    tbl[4] = '{"rnd_7fff", 16'h7FFF, 16'h0001};
    tbl[5] = '{"rnd_8000", 16'h8000, 16'hFFFF};

    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.coef_wr = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;

    // Reset state and zero-coefficient output
    do_reset();
    #1;
    chk("rst_fir_valid", 32'(bus.fir_valid), 32'd0);
    chk("rst_fir_d", 32'(bus.fir_d), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    send(16'h7FFF, -99, 5'd0, 16'h0, y);
    chk("zero_coef", 32'(y), 32'h0);

    // Impulse response with in_valid held high
    do_reset();
    for (int k = 0; k < 32; k++) load_coef(5'(k), 16'(k * 16'h0400));
    idx = 0; nout = 0; last = -1; cyc = 0;
    while (nout < 32 && cyc < 3000) begin
      if (bus.fir_valid) begin
        chk("impulse", 32'(bus.fir_d), 32'(nout * 32'h200));
        if (last >= 0) chk("impulse_period", 32'(cyc - last), 32'd34);
        last = cyc;
        nout++;
      end
      if (bus.in_ready) begin
        if (idx < 32) begin
          bus.in_valid = 1'b1;
          bus.in_data  = (idx == 0) ? 16'h4000 : 16'h0000;
          idx++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("impulse_count", 32'(nout), 32'd32);

    // Saturation both ways
    do_reset();
    for (int k = 0; k < 32; k++) load_coef(5'(k), 16'h7FFF);
    for (int k = 0; k < 32; k++) send(16'h7FFF, -99, 5'd0, 16'h0, y);
    chk("sat_pos", 32'(y), 32'h7FFF);
    for (int k = 0; k < 32; k++) send(16'h8000, -99, 5'd0, 16'h0, y);
    chk("sat_neg", 32'(y), 32'h8000);

    // Rounding table
    do_reset();
    load_coef(5'd0, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].x, -99, 5'd0, 16'h0, y);
      chk(tbl[i].name, 32'(y), 32'(tbl[i].exp_d));
    end

    // in_valid held for 200 cycles: accepts every 34 cycles, ready low 33 cycles
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 16'h0123;
    run = 0; nacc = 0; lacc = -1;
    for (int c = 0; c < 200; c++) begin
      if (bus.in_ready) begin
        if (run > 0) chk("ready_low_len", 32'(run), 32'd33);
        run = 0;
        if (lacc >= 0) chk("accept_spacing", 32'(c - lacc), 32'd34);
        lacc = c;
        nacc++;
      end else begin
        run++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("accept_count", 32'(nacc), 32'd6);

    // Coefficient lockout during MAC, and write-with-accept used at once
    do_reset();
    load_coef(5'd0, 16'h4000);
    send(16'h1000, 5, 5'd0, 16'h7FFF, y);
    chk("lockout_first", 32'(y), 32'h0800);
    send(16'h1000, -99, 5'd0, 16'h0, y);
    chk("lockout_kept", 32'(y), 32'h0800);
    send(16'h1000, -1, 5'd0, 16'h2000, y);
    chk("wr_with_accept", 32'(y), 32'h0400);

    // Reset at cnt == 10 aborts the computation and clears coefficients
    do_reset();
    for (int k = 0; k < 32; k++) load_coef(5'(k), 16'h7FFF);
    bus.in_valid = 1'b1; bus.in_data = 16'h7FFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (2) begin
      if (bus.fir_valid) pulses++;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    repeat (40) begin
      if (bus.fir_valid) pulses++;
      @(negedge clk);
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);
    send(16'h7FFF, -99, 5'd0, 16'h0, y);
    chk("coef_cleared", 32'(y), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
